// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the 128-bit product accumulator.
package prod_acc_pkg;

  localparam int unsigned HALF_W = 64;
  localparam int unsigned DATA_W = 2 * HALF_W;

  localparam logic [DATA_W-1:0] ACC_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ADD_HI = 2'd1,
    OUT    = 2'd2
  } state_t;

endpackage

// File: rtl/add64_cin.sv
// 64-bit combinational adder with carry in and carry out.
module add64_cin
  import prod_acc_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  logic [HALF_W:0] w_full;

  assign w_full = (HALF_W+1)'(a) + (HALF_W+1)'(b) + (HALF_W+1)'(cin);
  assign sum    = w_full[HALF_W-1:0];
  assign cout   = w_full[HALF_W];

endmodule

// File: rtl/prod_acc128.sv
// Accumulates 128-bit products as two carry-chained 64-bit adds per term.
// Define PROD_ACC_SATURATE_EN to clamp the sum at all-ones on overflow.
module prod_acc128
  import prod_acc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [DATA_W-1:0] prod,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic              acc_ovf,
  output logic [CNT_W-1:0]  acc_count
);

  state_t              r_state;
  logic [HALF_W-1:0]   r_acc_lo;
  logic [HALF_W-1:0]   r_acc_hi;
  logic                r_c;
  logic [HALF_W-1:0]   r_hi;
  logic                r_last;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_prod_ready;
  logic                r_acc_valid;

  state_t              w_state_nxt;
  logic [HALF_W-1:0]   w_acc_lo_nxt;
  logic [HALF_W-1:0]   w_acc_hi_nxt;
  logic                w_c_nxt;
  logic [HALF_W-1:0]   w_hi_nxt;
  logic                w_last_nxt;
  logic                w_ovf_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic                w_sel_hi;
  logic [HALF_W-1:0]   w_add_a;
  logic [HALF_W-1:0]   w_add_b;
  logic                w_add_cin;
  logic [HALF_W-1:0]   w_add_sum;
  logic                w_add_cout;

  // One shared adder: low half in ACCEPT, high half plus stored carry in ADD_HI.
  assign w_sel_hi  = (r_state == ADD_HI);
  assign w_add_a   = w_sel_hi ? r_acc_hi : r_acc_lo;
  assign w_add_b   = w_sel_hi ? r_hi     : prod[HALF_W-1:0];
  assign w_add_cin = w_sel_hi & r_c;

  add64_cin u_add (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_lo_nxt = r_acc_lo;
    w_acc_hi_nxt = r_acc_hi;
    w_c_nxt      = r_c;
    w_hi_nxt     = r_hi;
    w_last_nxt   = r_last;
    w_ovf_nxt    = r_ovf;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      ACCEPT: begin
        if (prod_valid) begin
          w_acc_lo_nxt = w_add_sum;
          w_c_nxt      = w_add_cout;
          w_hi_nxt     = prod[DATA_W-1:HALF_W];
          w_last_nxt   = prod_last;
          w_state_nxt  = ADD_HI;
        end
      end
      ADD_HI: begin
        w_acc_hi_nxt = w_add_sum;
        if (w_add_cout) w_ovf_nxt = 1'b1;
`ifdef PROD_ACC_SATURATE_EN
        // Once overflowed, the sum stays pinned at all-ones for this accumulation.
        if (w_add_cout || r_ovf) begin
          w_acc_hi_nxt = ACC_ALL_ONES[DATA_W-1:HALF_W];
          w_acc_lo_nxt = ACC_ALL_ONES[HALF_W-1:0];
          w_ovf_nxt    = 1'b1;
        end
`endif
        if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
        w_state_nxt = r_last ? OUT : ACCEPT;
      end
      OUT: begin
        if (acc_ready) begin
          w_acc_lo_nxt = '0;
          w_acc_hi_nxt = '0;
          w_ovf_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ACCEPT;
        end
      end
      default: w_state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCEPT;
      r_acc_lo     <= '0;
      r_acc_hi     <= '0;
      r_c          <= 1'b0;
      r_hi         <= '0;
      r_last       <= 1'b0;
      r_ovf        <= 1'b0;
      r_cnt        <= '0;
      r_prod_ready <= 1'b1;
      r_acc_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc_lo     <= w_acc_lo_nxt;
      r_acc_hi     <= w_acc_hi_nxt;
      r_c          <= w_c_nxt;
      r_hi         <= w_hi_nxt;
      r_last       <= w_last_nxt;
      r_ovf        <= w_ovf_nxt;
      r_cnt        <= w_cnt_nxt;
      r_prod_ready <= (w_state_nxt == ACCEPT);
      r_acc_valid  <= (w_state_nxt == OUT);
    end
  end

  assign prod_ready = r_prod_ready;
  assign acc_valid  = r_acc_valid;
  assign acc_out    = {r_acc_hi, r_acc_lo};
  assign acc_ovf    = r_ovf;
  assign acc_count  = r_cnt;

endmodule
